// File: rtl/qns_pkg.sv
// Shared types and helpers for the noise-shaping quantizer back end.
package qns_pkg;

  // Default width of the signed multi-level quantizer code.
  localparam int IN_W_DEF = 3;

  // Signed quantizer code at the default width.
  typedef logic signed [IN_W_DEF-1:0] qns_code_t;

  // Number of unit DAC elements served by an in_w-bit code.
  function automatic int num_el(input int in_w);
    return (1 << (in_w - 1)) - 1;
  endfunction

  // Level count k for a legal odd code: number of elements switched on.
  function automatic int level_k(input int code, input int n_el);
    return (code + n_el) >>> 1;
  endfunction

endpackage

// File: rtl/qns_rot_therm.sv
// Combinational rotate-thermometer generator: turns a level count k and a
// start pointer into a unit-element enable vector, and computes the pointer
// for the next sample. With ROTATE = 0 it degenerates to a fixed thermometer
// anchored at element 0 and the pointer is passed through unchanged.
module qns_rot_therm #(
  parameter int NUM_EL = 3,
  parameter int K_W    = 3,
  parameter int PTR_W  = 2,
  parameter bit ROTATE = 1'b1
) (
  input  logic [K_W-1:0]    k,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_EL-1:0] el,
  output logic [PTR_W-1:0]  ptr_next
);

  // One guard bit covers ptr + k, which stays below 2*NUM_EL.
  localparam int CW = K_W + 1;

  logic [CW-1:0] k_ext;
  logic [CW-1:0] ptr_ext;

  assign k_ext   = CW'(k);
  assign ptr_ext = CW'(ptr);

  genvar gi;
  generate
    if (ROTATE) begin : g_rot
      logic [CW-1:0] sum;

      assign sum = ptr_ext + k_ext;
      // Single compare-subtract is enough because sum < 2*NUM_EL.
      assign ptr_next = PTR_W'((sum >= CW'(NUM_EL)) ? sum - CW'(NUM_EL) : sum);

      for (gi = 0; gi < NUM_EL; gi++) begin : g_el
        logic [CW-1:0] pos;
        logic [CW-1:0] off;
        assign pos = CW'(gi);
        // Distance of element gi from the start pointer, walking upward
        // and wrapping from NUM_EL-1 back to 0.
        assign off = (pos >= ptr_ext) ? pos - ptr_ext : pos + CW'(NUM_EL) - ptr_ext;
        assign el[gi] = (off < k_ext);
      end
    end else begin : g_static
      assign ptr_next = ptr;

      for (gi = 0; gi < NUM_EL; gi++) begin : g_el
        assign el[gi] = (CW'(gi) < k_ext);
      end
    end
  endgenerate

endmodule

// File: rtl/qns_dwa_encoder.sv
// DWA encoder: converts the quantizer's odd signed code into unit-element
// enables for a thermometer DAC, flags and counts illegal codes.
// Build option: define QNS_DWA_EN for rotating data-weighted averaging;
// without it the mapping is a static thermometer and ptr stays 0.
module qns_dwa_encoder
  import qns_pkg::*;
#(
  parameter  int IN_W   = IN_W_DEF,
  parameter  int ERR_W  = 8,
  localparam int NUM_EL = num_el(IN_W),
  localparam int PTR_W  = (NUM_EL > 1) ? $clog2(NUM_EL) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic signed [IN_W-1:0] in,
  output logic [NUM_EL-1:0]      el_out,
  output logic                   valid_out,
  output logic [PTR_W-1:0]       ptr,
  output logic [ERR_W-1:0]       err_cnt
);

  localparam int K_W = IN_W;
  localparam logic signed [IN_W:0] MIN_CODE = (IN_W+1)'(-NUM_EL);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

`ifdef QNS_DWA_EN
  localparam bit ROTATE = 1'b1;
`else
  localparam bit ROTATE = 1'b0;
`endif

  logic [NUM_EL-1:0] el_reg;
  logic              valid_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [ERR_W-1:0]  err_reg;

  logic signed [IN_W:0] in_ext;
  logic signed [IN_W:0] sum;
  logic [K_W-1:0]       k;
  logic                 illegal;
  logic [NUM_EL-1:0]    el_next;
  logic [PTR_W-1:0]     ptr_next;

  // Level count k = (in + NUM_EL) >> 1 evaluated one bit wider than the code.
  assign in_ext  = {in[IN_W-1], in};
  assign sum     = in_ext + MIN_CODE * -1;
  assign k       = sum[K_W:1];
  assign illegal = ~in[0] | (in_ext < MIN_CODE);

  qns_rot_therm #(
    .NUM_EL (NUM_EL),
    .K_W    (K_W),
    .PTR_W  (PTR_W),
    .ROTATE (ROTATE)
  ) u_rot (
    .k        (k),
    .ptr      (ptr_reg),
    .el       (el_next),
    .ptr_next (ptr_next)
  );

  // Output, pointer and error-counter registers; illegal codes only count.
  always_ff @(posedge clock) begin
    if (reset) begin
      el_reg    <= '0;
      valid_reg <= 1'b0;
      ptr_reg   <= '0;
      err_reg   <= '0;
    end else begin
      valid_reg <= valid_in;
      if (valid_in) begin
        if (illegal) begin
          if (err_reg != ERR_MAX) begin
            err_reg <= err_reg + 1'b1;
          end
        end else begin
          el_reg  <= el_next;
          ptr_reg <= ptr_next;
        end
      end
    end
  end

  assign el_out    = el_reg;
  assign valid_out = valid_reg;
  assign ptr       = ptr_reg;
  assign err_cnt   = err_reg;

endmodule

// File: tb/tb_qns_dwa_encoder.sv
// Self-checking bench for qns_dwa_encoder (default parameters). The expected
// behaviour follows the QNS_DWA_EN setting the bench is compiled with.
module tb_qns_dwa_encoder;

  localparam int IN_W  = 3;
  localparam int N     = 3;
  localparam int ERR_W = 8;
  localparam int ERR_MAX = 255;

  logic                   clk;
  logic                   reset;
  logic                   valid_in;
  logic signed [IN_W-1:0] in_s;
  logic [N-1:0]           el_out;
  logic                   valid_out;
  logic [1:0]             ptr;
  logic [ERR_W-1:0]       err_cnt;

  int total_cnt;
  int fail_cnt;

  // Reference model state.
  int m_el;
  int m_valid;
  int m_ptr;
  int m_err;

  qns_dwa_encoder dut (
    .clock     (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .in        (in_s),
    .el_out    (el_out),
    .valid_out (valid_out),
    .ptr       (ptr),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    total_cnt++;
    assert (obs === exp_v) else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".el_out"},    int'(el_out),    m_el);
    check({tag, ".valid_out"}, int'(valid_out), m_valid);
    check({tag, ".ptr"},       int'(ptr),       m_ptr);
    check({tag, ".err_cnt"},   int'(err_cnt),   m_err);
  endtask

  // Behavioural model: choose k elements starting at the pointer.
  task automatic model(input bit v, input int code);
    int k;
    m_valid = v;
    if (v) begin
      if ((code % 2) == 0 || code < -N) begin
        if (m_err < ERR_MAX) m_err++;
      end else begin
        k = (code + N) / 2;
        m_el = 0;
        for (int j = 0; j < k; j++) begin
`ifdef QNS_DWA_EN
          m_el |= 1 << ((m_ptr + j) % N);
`else
          m_el |= 1 << j;
`endif
        end
`ifdef QNS_DWA_EN
        m_ptr = (m_ptr + k) % N;
`endif
      end
    end
  endtask

  task automatic step(input bit v, input int code, input bit chk, input string tag);
    valid_in = v;
    in_s     = IN_W'(code);
    @(posedge clk);
    #1;
    model(v, int'(in_s));
    if (chk) begin
      check_all(tag);
      $display("txn %s v=%0d in=%0d el=%b ptr=%0d err=%0d", tag, v, int'(in_s), el_out, ptr, err_cnt);
    end
  endtask

  task automatic do_reset(input int cycles, input bit v_during, input int code);
    reset    = 1'b1;
    valid_in = v_during;
    in_s     = IN_W'(code);
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
    valid_in = 1'b0;
    m_el = 0; m_valid = 0; m_ptr = 0; m_err = 0;
    check("reset.el_out",    int'(el_out),    0);
    check("reset.valid_out", int'(valid_out), 0);
    check("reset.ptr",       int'(ptr),       0);
    check("reset.err_cnt",   int'(err_cnt),   0);
    $display("txn reset el=%b ptr=%0d err=%0d", el_out, ptr, err_cnt);
  endtask

  initial begin
    int code;
    bit v;
    total_cnt = 0;
    fail_cnt  = 0;
    reset     = 1'b1;
    valid_in  = 1'b0;
    in_s      = '0;

    // Reset for two cycles.
    do_reset(2, 1'b0, 0);

    // k = 2 rotation, then k = 1 rotation (ends at ptr 1 in the DWA build).
    for (int i = 0; i < 3; i++) step(1'b1, 1, 1'b1, "k2");
    for (int i = 0; i < 4; i++) step(1'b1, -1, 1'b1, "k1");

    // Full scale and zero scale leave the pointer alone.
    step(1'b1, 3, 1'b1, "full");
    step(1'b1, -3, 1'b1, "zero");

    // Set a known pattern, then feed illegal codes.
    step(1'b1, -1, 1'b1, "pre_ill");
    step(1'b1, 0, 1'b1, "ill0");
    step(1'b1, 2, 1'b1, "ill2");
    step(1'b1, -4, 1'b1, "ill_m4");

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) step(1'b1, ((i % 2) == 0) ? 0 : -2, 1'b0, "sat");
    check_all("sat");
    check("sat.const", int'(err_cnt), ERR_MAX);

    // valid_in low: everything holds.
    step(1'b1, 1, 1'b1, "pre_gate");
    for (int i = 0; i < 5; i++) step(1'b0, 3, 1'b1, "gate");

    // Reset mid-stream beats a valid code; next +1 starts from ptr 0.
    step(1'b1, -1, 1'b1, "stream");
    do_reset(1, 1'b1, 3);
    step(1'b1, 1, 1'b1, "post_rst");
    check("post_rst.const", int'(el_out), 3);

    // Static-style repetition of -1.
    for (int i = 0; i < 4; i++) step(1'b1, -1, 1'b1, "rep_m1");

    // Randomized stream over the whole code range.
    for (int i = 0; i < 200; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      code = int'($urandom_range(0, 7)) - 4;
      step(v, code, 1'b1, "rand");
    end

    $display("%0d/%0d checks passed", total_cnt - fail_cnt, total_cnt);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qns_dwa_encoder.md
# qns_dwa_encoder

Downstream stage of the second-order noise-shaping quantizer. Consumes the quantizer's signed multi-level code and its valid strobe. Converts each code into a unit-element enable vector for a thermometer DAC. Data-weighted averaging (DWA) rotates element selection so mismatch is first-order noise-shaped. Flags illegal codes and counts them.

## Interface
- IN_W, 3: width of the signed quantizer code. Legal codes are the odd values in [-NUM_EL, NUM_EL].
- NUM_EL, derived localparam 2**(IN_W-1)-1 (3 at default): number of unit DAC elements.
- ERR_W, 8: width of the saturating illegal-code counter.
- clock, input, 1: single clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-high.
- valid_in, input, 1: code strobe from the quantizer.
- in, input, IN_W, signed: quantizer code.
- el_out, output, NUM_EL: element enables; bit i drives unit element i.
- valid_out, output, 1: one-cycle pulse per accepted input.
- ptr, output, $clog2(NUM_EL): current DWA start pointer (debug/verification).
- err_cnt, output, ERR_W: saturating count of illegal codes.

## Operation
- Level count: k = (in + NUM_EL) >> 1, computed in IN_W+1 bits; k ∈ [0, NUM_EL] for legal codes.
- A code is illegal if it is even or if in < -NUM_EL (e.g. -4 at IN_W=3).
- On a legal valid_in:
  - el_out bit (ptr + j) mod NUM_EL is set for j = 0..k-1; all other bits clear.
  - ptr ← (ptr + k) mod NUM_EL, using compare-subtract with no divider.
- Boundary cases:
  - k = 0: el_out = 0, ptr unchanged.
  - k = NUM_EL: el_out all ones, ptr unchanged.
  - Wrap-around: selection continues from bit NUM_EL-1 to bit 0.
- On an illegal valid_in:
  - el_out holds its previous value and ptr is unchanged.
  - valid_out still pulses.
  - err_cnt increments, saturating at 2**ERR_W-1.
- valid_in low: el_out, ptr and err_cnt hold; valid_out = 0.
- valid_in may stay high every cycle; each cycle is one sample. No backpressure.

## Timing
- Fully registered. Latency is 1 cycle: valid_in/in sampled at edge t appear as el_out/valid_out after edge t; ptr updates on the same edge.
- Reset values: el_out = 0, valid_out = 0, ptr = 0, err_cnt = 0.
- Reset asserted mid-stream wins over valid_in in that cycle. The first sample after reset deassertion uses ptr = 0.

## Configuration
- QNS_DWA_EN defined: rotating DWA selection as described above.
- QNS_DWA_EN undefined: static thermometer mapping.
  - el_out bits 0..k-1 are set.
  - ptr is held at 0.
- Illegal-code handling, latency and valid_out behaviour are identical in both builds.

## Structure
- Shared package qns_pkg:
  - Typedef for the signed quantizer code.
  - IN_W default.
  - Function returning NUM_EL from IN_W.
  - Function mapping code to level count k.
- One sub-module, qns_rot_therm: combinational rotate-thermometer generator (k, ptr) → enable vector, plus next-pointer.
- Top level holds the registers, legality check and error counter.

## Test plan
- Reset check: assert reset for 2 cycles → el_out = 3'b000, valid_out = 0, ptr = 0, err_cnt = 0.
- Rotation, k = 2: in = +1 for 3 consecutive cycles → el_out = 011, 101, 110; ptr = 2, 1, 0; valid_out high each cycle.
- Rotation, k = 1: in = -1 for 4 cycles → el_out = 001, 010, 100, 001.
- Full scale and wrap: from ptr = 1, in = +3 → el_out 111, ptr stays 1; in = -3 → el_out 000, ptr stays 1.
- Illegal codes: after el_out = 010, in = 0, then 2, then -4 → el_out stays 010, err_cnt = 1, 2, 3, ptr unchanged. Drive 300 illegal codes → err_cnt = 255.
- Gating and reset: valid_in low for 5 cycles → outputs hold, valid_out = 0. Reset during a stream → next legal +1 gives el_out = 011.
- Static build (QNS_DWA_EN undefined): in = -1 repeated → el_out = 001 every sample, ptr = 0.
